stream_reorder: RTL
===================

# stream_reorder

Parametrised, handshaked streaming-operator engine that generalises the fixed `{ << 8 {x} }` byte reversal to runtime-selectable slice size, direction and multi-word operand concatenation, i.e. `{ << S {w0, w1, ...} }` and `{ >> {w0, w1, ...} }`. It collects a frame of 1..MAX_WORDS input words, reorders the concatenated vector, and emits the result word-serially. It sits between a word-stream producer and consumer as a drop-in bit/byte/word reordering stage.

## Interface
- DATA_W, 32, word width in bits; power of two, at least 2.
- MAX_WORDS, 2, maximum words per frame; at least 1.
- SL_W, $clog2(DATA_W)+1, width of cfg_slice_log2 (derived).
- CNT_W, $clog2(MAX_WORDS+1), width of cfg_words (derived).

Ports:
- clk  in  1  clock; all registers on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- cfg_dir  in  1  1 = left-stream (`<<`, reverse slices); 0 = right-stream (`>>`, pass-through concat).
- cfg_slice_log2  in  SL_W  slice width = 2^value bits. Legal range is 0..log2(DATA_W); larger values are treated as log2(DATA_W).
- cfg_words  in  CNT_W  words per frame. A value of 0 is treated as 1; values above MAX_WORDS are clamped to MAX_WORDS.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- in_data  in  DATA_W  input word.
- out_valid  out  1  output beat valid.
- out_ready  in  1  consumer ready.
- out_data  out  DATA_W  output word.
- out_last  out  1  final word of frame; qualified by out_valid.
- busy  out  1  frame in progress (partial collect or emitting).

## Operation
- States:
  - COLLECT (reset state): in_ready=1, out_valid=0.
  - EMIT: in_ready=0, out_valid=1.
- Config latching:
  - cfg_dir, cfg_slice_log2 and cfg_words are latched, after clamping, on the first accepted beat of a frame.
  - Config changes later in the frame are ignored.
- COLLECT:
  - Each handshake stores in_data at buffer index cnt, then increments cnt.
  - On the handshake that brings cnt to N, the state moves to EMIT and cnt clears.
- Concatenation: V = {w0, w1, ..., wN-1}. The first accepted word is most significant. Width of V is N*DATA_W.
- Reorder:
  - Left-stream: result R holds the slices of V in reversed order. Slice k counted from the MSB of R equals slice k counted from the LSB of V. Bit order within each slice is preserved.
  - Right-stream: R = V.
  - A slice width of DATA_W therefore reverses word order. Slice widths always divide N*DATA_W.
- EMIT:
  - out_data = word j of R, counted from the MSB (j=0 first).
  - On each out_valid && out_ready, j increments.
  - out_last=1 when j=N-1. The handshake at j=N-1 returns the state to COLLECT.
- No frame overlap: new input is never accepted while emitting.
- busy = (state==EMIT) || (cnt!=0).
- The reorder may be computed combinationally from the buffer or registered at the EMIT transition. Either way, out_data must be stable while out_valid && !out_ready.

## Timing
- Reset values, held while rst=1: in_ready=0, out_valid=0, out_last=0, out_data=0, busy=0. Internal cnt, j and the buffer are cleared.
- Reset deassertion: in_ready=1 from the first cycle after rst is low.
- Latency: out_valid rises in the cycle after the Nth input handshake.
- Throughput: one frame per 2N cycles at full handshake rate.
- Back-pressure: while out_ready=0, out_data and out_last hold their values and in_valid is ignored.
- in_valid=0 during COLLECT: stall with no state change. Gaps between beats of a frame are allowed.
- Reset mid-frame (COLLECT or EMIT): the partial frame is discarded. The next frame starts at w0 with freshly latched config.
- N=1: single-beat collect and single-beat emit, with out_last=1 on that beat.

## Test plan
- Byte reverse, DATA_W=32, N=1, left, slice_log2=3: in 0x172A7FFF -> out 0xFF7F2A17 with out_last=1, one cycle after the input handshake.
- Two-word byte reverse, N=2, left, slice_log2=3:
  - Stimulus: in 0x01234567 then 0x89ABCDEF.
  - Required: out 0xEFCDAB89 (last=0), then 0x67452301 (last=1).
- Right-stream and word-slice cases, N=2, same input words:
  - Right-stream -> out 0x01234567, 0x89ABCDEF.
  - Left with slice_log2=5 -> out 0x89ABCDEF, 0x01234567.
- Bit reverse and clamping:
  - Left, slice_log2=0, N=1, in 0x00000001 -> 0x80000000.
  - cfg_words=0 behaves as N=1.
  - cfg_slice_log2=7 behaves as 5.
- Back-pressure:
  - Stimulus: N=2 frame with out_ready=0 for 3 cycles on each output word, while in_valid pulses during EMIT.
  - Required: out_data stable, in_ready=0, pulses not consumed, next frame is correct.
- Reset:
  - Async rst pulse after 1 of 2 beats: all outputs 0 immediately, busy=0. A following N=2 frame produces the correct result.
  - cfg change between beats of a frame: ignored.

Source files
------------

// File: rtl/stream_reorder.sv
// Streaming-operator engine: collects a frame of 1..MAX_WORDS words, applies
// {<< S {w0..wN-1}} or {>> {w0..wN-1}}, and emits the result word-serially.
module stream_reorder #(
  parameter int DATA_W    = 32,
  parameter int MAX_WORDS = 2,
  parameter int SL_W      = $clog2(DATA_W) + 1,
  parameter int CNT_W     = $clog2(MAX_WORDS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_dir,
  input  logic [SL_W-1:0]   cfg_slice_log2,
  input  logic [CNT_W-1:0]  cfg_words,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy
);

  // state   | meaning
  // COLLECT | accepting input beats into the frame buffer
  // EMIT    | presenting reordered words, no input accepted

  localparam int LOG2W = $clog2(DATA_W);
  localparam int TOT   = DATA_W * MAX_WORDS;
  localparam int IDX_W = (TOT > 1) ? $clog2(TOT) : 1;

  typedef enum logic {COLLECT, EMIT} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [CNT_W-1:0]   j, j_nxt;
  logic [CNT_W-1:0]   n_q;
  logic               dir_q;
  logic [SL_W-1:0]    slice_q;
  logic [DATA_W-1:0]  buffer [MAX_WORDS];

  logic [CNT_W-1:0]   words_clamp;
  logic [CNT_W-1:0]   n_eff;
  logic [SL_W-1:0]    slice_clamp;
  logic               in_fire;
  logic               out_fire;
  logic [TOT-1:0]     vec;
  logic [TOT-1:0]     res;
  logic [DATA_W-1:0]  out_word;

  always_comb begin
    words_clamp = cfg_words;
    if (cfg_words == '0)
      words_clamp = CNT_W'(1);
    else if (cfg_words > CNT_W'(MAX_WORDS))
      words_clamp = CNT_W'(MAX_WORDS);
    slice_clamp = (cfg_slice_log2 > SL_W'(LOG2W)) ? SL_W'(LOG2W) : cfg_slice_log2;
  end

  // The first beat of a frame must already use the incoming word count.
  assign n_eff = (cnt == '0) ? words_clamp : n_q;

  assign in_ready  = !rst && (state == COLLECT);
  assign out_valid = (state == EMIT);
  assign out_last  = out_valid && (j == n_q - CNT_W'(1));
  assign busy      = (state == EMIT) || (cnt != '0);
  assign out_data  = out_valid ? out_word : '0;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    j_nxt     = j;
    case (state)
      COLLECT: begin
        if (in_fire) begin
          if (cnt + CNT_W'(1) == n_eff) begin
            state_nxt = EMIT;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      EMIT: begin
        if (out_fire) begin
          if (j == n_q - CNT_W'(1)) begin
            state_nxt = COLLECT;
            j_nxt     = '0;
          end else begin
            j_nxt = j + CNT_W'(1);
          end
        end
      end
      default: state_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= COLLECT;
      cnt     <= '0;
      j       <= '0;
      n_q     <= '0;
      dir_q   <= 1'b0;
      slice_q <= '0;
      for (int k = 0; k < MAX_WORDS; k++)
        buffer[k] <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      j     <= j_nxt;
      if (in_fire) begin
        if (cnt == '0) begin
          dir_q   <= cfg_dir;
          slice_q <= slice_clamp;
          n_q     <= words_clamp;
        end
        for (int k = 0; k < MAX_WORDS; k++)
          if (cnt == CNT_W'(k))
            buffer[k] <= in_data;
      end
    end
  end

  // Slice reversal = full bit reversal of V followed by bit reversal inside
  // each slice; the latter is an XOR of the bit index with (S-1).
  always_comb begin
    int n_i;
    int len;
    int s_m1;
    vec  = '0;
    res  = '0;
    n_i  = int'(n_q);
    len  = n_i * DATA_W;
    s_m1 = (1 << int'(slice_q)) - 1;
    for (int k = 0; k < MAX_WORDS; k++)
      if (k < n_i)
        vec[IDX_W'((n_i - 1 - k) * DATA_W) +: DATA_W] = buffer[k];
    if (dir_q) begin
      for (int i = 0; i < TOT; i++)
        if (i < len)
          res[IDX_W'(i)] = vec[IDX_W'(len - 1 - (i ^ s_m1))];
    end else begin
      res = vec;
    end
    out_word = res[IDX_W'((n_i - 1 - int'(j)) * DATA_W) +: DATA_W];
  end

endmodule
